// File: rtl/key_matrix_scan_if.sv
// Keypad-side bundle of the matrix scanner: column sense in, row drive and
// debounced key events out.
interface key_matrix_scan_if;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] key_state;
    logic        key_valid;
    logic [3:0]  key_code;

    modport master (
        input  col_in,
        output row_out,
        output key_state,
        output key_valid,
        output key_code
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_state,
        input  key_valid,
        input  key_code
    );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: active-low row drive, synchronized column sense,
// frame-level debounce and one-cycle new-press events.
module key_matrix_scan #(
    parameter int SCAN_CNT   = 50000,
    parameter int DEB_FRAMES = 5
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    key_matrix_scan_if.master  kp
);
    localparam int SLOT_W  = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int MATCH_W = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SCAN_CNT - 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEB_FRAMES - 1);

    typedef enum logic [0:0] {
        ST_SCAN,
        ST_EVAL
    } phase_t;

    phase_t             state_reg, state_next;
    logic [3:0]         col_meta_reg, col_sync_reg;
    logic [SLOT_W-1:0]  slot_cnt_reg;
    logic [1:0]         row_idx_reg;
    logic [3:0]         row_out_reg;
    logic [15:0]        snapshot_reg, snapshot_next;
    logic [15:0]        prev_frame_reg;
    logic [MATCH_W-1:0] match_reg, match_next;
    logic [15:0]        key_state_reg;
    logic               key_valid_reg;
    logic [3:0]         key_code_reg;

    logic        slot_end;
    logic        frame_end;
    logic        do_eval;
    logic        accept;
    logic [15:0] newpress;

    function automatic logic [3:0] lowest_index(input logic [15:0] v);
        lowest_index = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_index = 4'(i);
        end
    endfunction

    assign slot_end  = (slot_cnt_reg == SLOT_LAST);
    assign frame_end = slot_end && (row_idx_reg == 2'd3);

    // Each row nibble of the snapshot is refreshed only at the end of its own slot.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row_store
            assign snapshot_next[gi*4 +: 4] =
                (slot_end && (row_idx_reg == 2'(gi))) ? ~col_sync_reg
                                                      : snapshot_reg[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        do_eval    = 1'b0;
        case (state_reg)
            ST_SCAN: begin
                if (frame_end) state_next = ST_EVAL;
            end
            ST_EVAL: begin
                do_eval    = 1'b1;
                state_next = ST_SCAN;
            end
            default: state_next = ST_SCAN;
        endcase
    end

    always_comb begin
        match_next = '0;
        if (snapshot_reg == prev_frame_reg) begin
            match_next = (match_reg == MATCH_MAX) ? MATCH_MAX : match_reg + MATCH_W'(1);
        end
    end

    // Acceptance is only meaningful when the debounced view would actually change.
    assign accept   = (match_next == MATCH_MAX) && (snapshot_reg != key_state_reg);
    assign newpress = snapshot_reg & ~key_state_reg;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg      <= ST_SCAN;
            col_meta_reg   <= 4'b1111;
            col_sync_reg   <= 4'b1111;
            slot_cnt_reg   <= '0;
            row_idx_reg    <= 2'd0;
            row_out_reg    <= 4'b1110;
            snapshot_reg   <= '0;
            prev_frame_reg <= '0;
            match_reg      <= '0;
            key_state_reg  <= '0;
            key_valid_reg  <= 1'b0;
            key_code_reg   <= 4'd0;
        end else begin
            state_reg     <= state_next;
            col_meta_reg  <= kp.col_in;
            col_sync_reg  <= col_meta_reg;
            slot_cnt_reg  <= slot_end ? '0 : slot_cnt_reg + SLOT_W'(1);
            snapshot_reg  <= snapshot_next;
            key_valid_reg <= 1'b0;

            if (slot_end) begin
                row_idx_reg <= row_idx_reg + 2'd1;
                row_out_reg <= {row_out_reg[2:0], row_out_reg[3]};
            end

            if (do_eval) begin
                match_reg      <= match_next;
                prev_frame_reg <= snapshot_reg;
                if (accept) begin
                    key_state_reg <= snapshot_reg;
                    if (newpress != 16'd0) begin
                        key_valid_reg <= 1'b1;
                        key_code_reg  <= lowest_index(newpress);
                    end
                end
            end
        end
    end

    assign kp.row_out   = row_out_reg;
    assign kp.key_state = key_state_reg;
    assign kp.key_valid = key_valid_reg;
    assign kp.key_code  = key_code_reg;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: ideal keypad model, frame-level debounce model,
// directed scenarios followed by random held patterns.
module tb_key_matrix_scan;
    localparam int SCAN  = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * SCAN;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic [15:0] pressed = '0;

    key_matrix_scan_if kp();

    key_matrix_scan #(.SCAN_CNT(SCAN), .DEB_FRAMES(DEB)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kp        (kp)
    );

    always #5 sys_clk = ~sys_clk;

    // Ideal switch matrix: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        kp.col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp.row_out[r] && pressed[r*4+c]) kp.col_in[c] = 1'b0;
            end
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int press_cyc;
    int pulse_cyc;

    logic [15:0] m_state;
    logic [3:0]  m_code;
    logic [15:0] m_hist[$];
    int          exp_pulses;
    logic [15:0] exp_state;
    logic [3:0]  exp_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A frame's snapshot is simply the pressed set; accept once DEB identical frames in a row.
    task automatic model_frame(input logic [15:0] s);
        logic        all_eq;
        logic [15:0] np;
        m_hist.push_back(s);
        while (m_hist.size() > DEB) void'(m_hist.pop_front());
        all_eq = (m_hist.size() == DEB);
        foreach (m_hist[i]) if (m_hist[i] != s) all_eq = 1'b0;
        exp_pulses = 0;
        if (all_eq && s != m_state) begin
            np = s & ~m_state;
            if (np != 16'd0) begin
                exp_pulses = 1;
                for (int i = 15; i >= 0; i--) if (np[i]) m_code = 4'(i);
            end
            m_state = s;
        end
        exp_state = m_state;
        exp_code  = m_code;
    endtask

    task automatic model_reset();
        m_state    = '0;
        m_code     = '0;
        m_hist.delete();
        exp_pulses = 0;
        exp_state  = '0;
        exp_code   = '0;
    endtask

    // Called at the negedge that opens a frame (row 0, slot 0).
    task automatic run_frame(input logic [15:0] pat);
        int          pulses;
        logic [3:0]  er;
        pressed = pat;
        pulses  = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge sys_clk);
            cyc++;
            er = 4'b0001 << ((k / SCAN) % 4);
            er = ~er;
            chk("row_out", 32'(kp.row_out), 32'(er));
            if (kp.key_valid === 1'b1) begin
                pulses++;
                pulse_cyc = cyc;
            end
        end
        chk("pulse_count", 32'(pulses), 32'(exp_pulses));
        chk("key_state", 32'(kp.key_state), 32'(exp_state));
        chk("key_code", 32'(kp.key_code), 32'(exp_code));
        model_frame(pat);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        chk("rst_row_out", 32'(kp.row_out), 32'h0000_000E);
        chk("rst_key_state", 32'(kp.key_state), 32'd0);
        chk("rst_key_valid", 32'(kp.key_valid), 32'd0);
        chk("rst_key_code", 32'(kp.key_code), 32'd0);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] pat;
        int          hold;
        bit          lat_ok;

        model_reset();
        do_reset();

        // Idle scanning
        repeat (4) run_frame(16'h0000);

        // Clean press of key 6, then release
        press_cyc = cyc;
        pulse_cyc = -1;
        repeat (6) run_frame(16'h0040);
        lat_ok = (pulse_cyc > press_cyc) && (pulse_cyc - press_cyc <= (DEB + 1) * FRAME + 3);
        chk("press_latency_ok", 32'(lat_ok), 32'd1);
        repeat (4) run_frame(16'h0000);

        // Bounce on key 6
        for (int f = 0; f < 8; f++) run_frame((f % 2 == 0) ? 16'h0040 : 16'h0000);
        repeat (4) run_frame(16'h0000);

        // Keys 3 and 12 together, then release 3
        repeat (5) run_frame(16'h1008);
        repeat (5) run_frame(16'h1000);

        // Key 5 added to held key 12
        repeat (5) run_frame(16'h1020);
        repeat (3) run_frame(16'h0000);

        // Key 9 held across a mid-scan reset
        repeat (2) run_frame(16'h0200);
        repeat (7) begin
            @(negedge sys_clk);
            cyc++;
        end
        do_reset();
        repeat (5) run_frame(16'h0200);
        repeat (3) run_frame(16'h0000);

        // Random held patterns
        repeat (40) begin
            pat = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) pat = 16'h0000;
            hold = $urandom_range(1, 5);
            repeat (hold) run_frame(pat);
        end
        run_frame(16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
